// File: rtl/sdr_pkg.sv
// sdr_pkg: shared FSM state encoding and derived timing for the subband filter coefficient sequencer.
package sdr_pkg;
    typedef enum logic [2:0] {S_RUN, S_DRAIN, S_RST, S_LOAD, S_FLUSH} state_t;
    // Idle cycles after the last filter input before the filter pipeline is empty and safe to reset.
    function automatic int drain_len(input int ncoeffs);
        return ncoeffs + 4;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that saturates at LIMIT; reset preloads LIMIT.
module sat_counter #(
    parameter int W = 8,
    parameter int LIMIT = 255
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    output logic [W-1:0] o_count
);
    logic [W-1:0] count_q;
    always_ff @(posedge i_clk) begin
        if (i_reset)
            count_q <= W'(LIMIT);
        else if (i_clear)
            count_q <= '0;
        else if (count_q != W'(LIMIT))
            count_q <= count_q + 1'b1;
    end
    assign o_count = count_q;
endmodule

// File: rtl/subfil_coeff_sequencer.sv
// subfil_coeff_sequencer: paces samples into a subband filter and reloads its coefficient bank from ROM,
// draining the filter first and discarding the contaminated outputs after each reload.
module subfil_coeff_sequencer
    import sdr_pkg::*;
#(
    parameter int IW = 16,
    parameter int CW = 12,
    parameter int NCOEFFS = 103,
    parameter int NBANKS = 4,
    parameter int NDOWN = 5,
    parameter int MIN_SPACING = 22,
    parameter int NFLUSH = 21,
    localparam int LGNCOEFFS = $clog2(NCOEFFS),
    localparam int LGNBANKS = $clog2(NBANKS),
    localparam int DRAIN = drain_len(NCOEFFS)
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_load_req,
    input  logic [LGNBANKS-1:0]           i_bank,
    output logic                          o_busy,
    output logic                          o_done,
    input  logic                          i_valid,
    input  logic [IW-1:0]                 i_sample_i,
    input  logic [IW-1:0]                 i_sample_q,
    output logic                          o_ready,
    output logic                          o_fil_ce,
    output logic [IW-1:0]                 o_sample_i,
    output logic [IW-1:0]                 o_sample_q,
    output logic                          o_fil_reset,
    output logic                          o_wr_coeff,
    output logic [CW-1:0]                 o_coeff,
    output logic [LGNBANKS+LGNCOEFFS-1:0] o_rom_addr,
    input  logic [CW-1:0]                 i_rom_data,
    input  logic                          i_fil_oce,
    output logic                          o_out_valid
);
    localparam int GW = $clog2(DRAIN + 1);
    localparam int DW = $clog2(NFLUSH + 1);
    localparam int AW = LGNBANKS + LGNCOEFFS;

    // Each decimated output spans NDOWN inputs, so NFLUSH outputs must cover the whole zeroed history.
    if (NFLUSH * NDOWN < NCOEFFS) begin : g_flush_too_short
        $error("NFLUSH does not cover the filter history after a reload");
    end

    state_t              state_q;
    logic [GW-1:0]       gap_cnt;
    logic [LGNBANKS-1:0] bank_q;
    logic [AW-1:0]       addr_q;
    logic [DW-1:0]       disc_q, disc_d;
    logic [IW-1:0]       smp_i_q, smp_q_q;
    logic                hs, fil_ce_q, wr_q, done_q, busy_q, fil_reset_q;

    assign o_ready = state_q == S_RUN && gap_cnt >= GW'(MIN_SPACING - 1);
    assign hs = i_valid && o_ready;

    // Cleared on the handshake so the count reads 0 while o_fil_ce is high.
    sat_counter #(.W(GW), .LIMIT(DRAIN)) u_gap (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_clear(hs),
        .o_count(gap_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (hs) begin
            smp_i_q <= i_sample_i;
            smp_q_q <= i_sample_q;
        end
        fil_ce_q <= !i_reset && hs;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_RST;
            bank_q      <= '0;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            fil_reset_q <= 1'b1;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_RUN: if (i_load_req) begin
                    bank_q  <= i_bank;
                    busy_q  <= 1'b1;
                    state_q <= S_DRAIN;
                end
                S_DRAIN: if (gap_cnt == GW'(DRAIN) && !fil_ce_q) begin
                    fil_reset_q <= 1'b1;
                    state_q     <= S_RST;
                end
                S_RST: begin
                    fil_reset_q <= 1'b0;
                    addr_q      <= {bank_q, LGNCOEFFS'(0)};
                    state_q     <= S_LOAD;
                end
                S_LOAD: begin
                    wr_q <= 1'b1;
                    if (addr_q[LGNCOEFFS-1:0] == LGNCOEFFS'(NCOEFFS - 1))
                        state_q <= S_FLUSH;
                    else
                        addr_q <= addr_q + 1'b1;
                end
                S_FLUSH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_RUN;
                end
                default: state_q <= S_RST;
            endcase
        end
    end

    assign disc_d = state_q == S_FLUSH ? DW'(NFLUSH)
                  : (i_fil_oce && disc_q != '0) ? disc_q - 1'b1 : disc_q;

    always_ff @(posedge i_clk) begin
        disc_q <= i_reset ? '0 : disc_d;
    end

    assign o_out_valid = i_fil_oce && disc_q == '0 && !i_reset;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_fil_ce    = fil_ce_q;
    assign o_sample_i  = smp_i_q;
    assign o_sample_q  = smp_q_q;
    assign o_fil_reset = fil_reset_q;
    assign o_wr_coeff  = wr_q;
    assign o_coeff     = i_rom_data;
    assign o_rom_addr  = addr_q;
endmodule

// File: tb/tb_subfil_coeff_sequencer.sv
// tb_subfil_coeff_sequencer: directed checks of boot load, strobe pacing, drain and reload, output discard
// and reset abort, against hand-computed cycle counts.
module tb_subfil_coeff_sequencer;
    logic        i_clk = 1'b0, i_reset = 1'b1, i_load_req = 1'b0, i_valid = 1'b0, i_fil_oce = 1'b0;
    logic [1:0]  i_bank = '0;
    logic [15:0] i_sample_i = '0, i_sample_q = '0;
    logic [11:0] i_rom_data = '0;
    logic        o_busy, o_done, o_ready, o_fil_ce, o_fil_reset, o_wr_coeff, o_out_valid;
    logic [15:0] o_sample_i, o_sample_q;
    logic [11:0] o_coeff;
    logic [8:0]  o_rom_addr;
    int          checks = 0, errors = 0, done_total = 0, ovl = 0;
    logic [11:0] wr_log[$];

    subfil_coeff_sequencer dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load_req (i_load_req),
        .i_bank     (i_bank),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .i_valid    (i_valid),
        .i_sample_i (i_sample_i),
        .i_sample_q (i_sample_q),
        .o_ready    (o_ready),
        .o_fil_ce   (o_fil_ce),
        .o_sample_i (o_sample_i),
        .o_sample_q (o_sample_q),
        .o_fil_reset(o_fil_reset),
        .o_wr_coeff (o_wr_coeff),
        .o_coeff    (o_coeff),
        .o_rom_addr (o_rom_addr),
        .i_rom_data (i_rom_data),
        .i_fil_oce  (i_fil_oce),
        .o_out_valid(o_out_valid)
    );

    always #5 i_clk = ~i_clk;

    // ROM model: one-cycle read latency, data tags the address it came from.
    always @(posedge i_clk) i_rom_data <= {3'b101, o_rom_addr};

    always @(negedge i_clk) begin
        if (o_wr_coeff) wr_log.push_back(o_coeff);
        if (o_done) done_total++;
        if (o_fil_ce && (o_fil_reset || o_wr_coeff)) ovl++;
    end

    task automatic step();
        @(negedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_load(input string tag, input int ls, input int bank);
        int bad;
        bad = 0;
        chk({tag, "_wr_count"}, wr_log.size() - ls, 103);
        for (int k = 0; k < 103 && ls + k < wr_log.size(); k++)
            if (wr_log[ls + k] !== {3'b101, 9'(bank * 128 + k)}) bad++;
        chk({tag, "_addr_seq"}, bad, 0);
    endtask

    task automatic wait_done(output int m);
        m = 0;
        while (!o_done && m < 300) begin
            step();
            m++;
        end
    endtask

    initial begin
        int m, n, ls, prev, first, nce, sp_bad, smp_bad, rdy_bad, sup, pass, bad;
        logic [15:0] last_d;
        last_d = '0;
        repeat (3) step();
        chk("rst_busy", o_busy, 1);
        chk("rst_fil_ce", o_fil_ce, 0);
        chk("rst_wr", o_wr_coeff, 0);
        chk("rst_done", o_done, 0);
        chk("rst_fil_reset", o_fil_reset, 1);
        i_fil_oce = 1'b1;
        #1;
        chk("rst_out_valid", o_out_valid, 0);
        i_fil_oce = 1'b0;
        i_reset = 1'b0;
        ls = wr_log.size();
        wait_done(m);
        chk("boot_len", m, 105);
        chk("boot_busy", o_busy, 0);
        chk("boot_ready", o_ready, 1);
        check_load("boot", ls, 0);

        i_valid = 1'b1;
        prev = -1; first = -1; nce = 0; sp_bad = 0; smp_bad = 0; rdy_bad = 0;
        for (int k = 0; k < 120; k++) begin
            if (prev >= 0 && k - prev == 20 && o_ready !== 1'b0) rdy_bad++;
            if (prev >= 0 && k - prev == 21 && o_ready !== 1'b1) rdy_bad++;
            if (o_fil_ce) begin
                nce++;
                if (first < 0) first = k;
                if (prev >= 0 && k - prev != 22) sp_bad++;
                if (o_sample_i !== last_d || o_sample_q !== ~last_d) smp_bad++;
                prev = k;
            end
            last_d = 16'(k * 37 + 5);
            i_sample_i = last_d;
            i_sample_q = ~last_d;
            step();
        end
        chk("run_first_ce", first, 1);
        chk("run_ce_count", nce, 6);
        chk("run_spacing", sp_bad, 0);
        chk("run_samples", smp_bad, 0);
        chk("run_ready", rdy_bad, 0);

        n = 0;
        while (!o_fil_ce && n < 100) begin
            step();
            n++;
        end
        chk("pre_load_ce_seen", o_fil_ce, 1);
        i_valid = 1'b0;
        repeat (5) step();
        i_load_req = 1'b1;
        i_bank = 2'd2;
        step();
        i_load_req = 1'b0;
        chk("drain_busy", o_busy, 1);
        chk("drain_addr_hold", o_rom_addr, 102);
        n = 6;
        while (!o_fil_reset && n < 300) begin
            i_load_req = (n == 20);
            i_bank = (n == 20) ? 2'd1 : 2'd2;
            step();
            n++;
        end
        i_load_req = 1'b0;
        chk("drain_len", n, 108);
        ls = wr_log.size();
        m = 0;
        while (!o_done && m < 300) begin
            i_load_req = (m == 10);
            i_bank = (m == 10) ? 2'd3 : 2'd2;
            step();
            m++;
        end
        i_load_req = 1'b0;
        chk("bank2_len", m, 105);
        check_load("bank2", ls, 2);

        sup = 0; pass = 0; bad = 0;
        for (int p = 0; p < 25; p++) begin
            i_fil_oce = 1'b1;
            #1;
            if (o_out_valid !== (p >= 21)) bad++;
            if (o_out_valid) pass++; else sup++;
            step();
            i_fil_oce = 1'b0;
            step();
        end
        chk("disc_suppressed", sup, 21);
        chk("disc_passed", pass, 4);
        chk("disc_order", bad, 0);

        bad = 0;
        repeat (150) begin
            step();
            if (o_busy || o_fil_reset) bad++;
        end
        chk("no_extra_reload", bad, 0);
        chk("done_after_two", done_total, 2);

        i_load_req = 1'b1;
        i_bank = 2'd1;
        step();
        i_load_req = 1'b0;
        n = 0;
        while (!o_fil_reset && n < 50) begin
            step();
            n++;
        end
        chk("quick_drain", n, 1);
        ls = wr_log.size();
        repeat (51) step();
        chk("abort_addr", o_rom_addr, 178);
        chk("abort_wr_count", wr_log.size() - ls, 50);
        i_reset = 1'b1;
        step();
        chk("abort_rst_wr", o_wr_coeff, 0);
        chk("abort_rst_fil_reset", o_fil_reset, 1);
        chk("abort_rst_busy", o_busy, 1);
        step();
        i_reset = 1'b0;
        ls = wr_log.size();
        wait_done(m);
        chk("reload_len", m, 105);
        check_load("reload", ls, 0);
        chk("reload_ready", o_ready, 1);
        chk("done_total", done_total, 3);
        chk("ce_overlap", ovl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
